// File: rtl/signal_control_lectura_pkg.sv
// Shared definitions for the RTC read/write sequencers: state encodings, default
// bus timing and the per-state control-line decode.
package signal_control_lectura_pkg;

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_ADDR_SETUP = 4'd1;
   localparam logic [3:0] ST_ADDR_STRB  = 4'd2;
   localparam logic [3:0] ST_ADDR_HOLD  = 4'd3;
   localparam logic [3:0] ST_GAP        = 4'd4;
   localparam logic [3:0] ST_DATA_SETUP = 4'd5;
   localparam logic [3:0] ST_DATA_STRB  = 4'd6;
   localparam logic [3:0] ST_DATA_HOLD  = 4'd7;
   localparam logic [3:0] ST_DONE       = 4'd8;

   localparam int T_SETUP_DEF  = 2;
   localparam int T_STROBE_DEF = 6;
   localparam int T_GAP_DEF    = 10;

   typedef struct packed {
      logic cs_l;
      logic rd_l;
      logic wr_l;
      logic a_d_l;
      logic en_tri;
   } bus_ctrl_t;

   // Control lines seen on the bus while the sequencer sits in a given state.
   function automatic bus_ctrl_t ctrl_of(input logic [3:0] st);
      bus_ctrl_t c;
      case (st)
         ST_ADDR_SETUP: c = '{cs_l: 1'b0, rd_l: 1'b1, wr_l: 1'b1, a_d_l: 1'b0, en_tri: 1'b1};
         ST_ADDR_STRB:  c = '{cs_l: 1'b0, rd_l: 1'b1, wr_l: 1'b0, a_d_l: 1'b0, en_tri: 1'b1};
         ST_ADDR_HOLD:  c = '{cs_l: 1'b0, rd_l: 1'b1, wr_l: 1'b1, a_d_l: 1'b0, en_tri: 1'b1};
         ST_DATA_SETUP: c = '{cs_l: 1'b0, rd_l: 1'b1, wr_l: 1'b1, a_d_l: 1'b1, en_tri: 1'b0};
         ST_DATA_STRB:  c = '{cs_l: 1'b0, rd_l: 1'b0, wr_l: 1'b1, a_d_l: 1'b1, en_tri: 1'b0};
         ST_DATA_HOLD:  c = '{cs_l: 1'b0, rd_l: 1'b1, wr_l: 1'b1, a_d_l: 1'b1, en_tri: 1'b0};
         default:       c = '{cs_l: 1'b1, rd_l: 1'b1, wr_l: 1'b1, a_d_l: 1'b1, en_tri: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/signal_control_lectura_contador_fase.sv
// contador_fase: loadable 6-bit phase down-counter; stops at zero instead of wrapping.
module contador_fase (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] load_val,
   output logic [5:0] count,
   output logic       zero
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != 6'd0)
         count <= count - 6'd1;
   end

   assign zero = (count == 6'd0);

endmodule

// File: rtl/signal_control_lectura.sv
// RTC read-cycle sequencer: address phase, bus release, data phase, byte capture.
// Optional macro RTC_RD_DOUBLE_SAMPLE_EN adds a mid-strobe sample and the rd_err check.
module signal_control_lectura
   import signal_control_lectura_pkg::*;
#(
   parameter int T_SETUP  = T_SETUP_DEF,
   parameter int T_STROBE = T_STROBE_DEF,
   parameter int T_GAP    = T_GAP_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] bus_in,
   output logic [7:0] addr_out,
   output logic       en_tri,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       rd_err,
   output logic       CS_l,
   output logic       RD_l,
   output logic       WR_l,
   output logic       A_D_l
);

   logic [3:0] state, state_nxt;
   logic       load;
   logic [5:0] load_val, count;
   logic       zero;
   bus_ctrl_t  ctrl_nxt;

   function automatic logic [5:0] dur_m1(input logic [3:0] st);
      case (st)
         ST_ADDR_SETUP, ST_DATA_SETUP: return 6'(T_SETUP - 1);
         ST_ADDR_STRB, ST_DATA_STRB:   return 6'(T_STROBE - 1);
         ST_GAP:                       return 6'(T_GAP - 1);
         default:                      return 6'd0;
      endcase
   endfunction

   contador_fase u_contador_fase (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .zero     (zero)
   );

   // States are encoded in bus order, so every timed state simply steps to the next code.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_ADDR_SETUP;
               load      = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            load      = 1'b1;
         end
         default: begin
            if (zero) begin
               state_nxt = state + 4'd1;
               load      = 1'b1;
            end
         end
      endcase
      load_val = dur_m1(state_nxt);
      ctrl_nxt = ctrl_of(state_nxt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         CS_l     <= 1'b1;
         RD_l     <= 1'b1;
         WR_l     <= 1'b1;
         A_D_l    <= 1'b1;
         en_tri   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         addr_out <= '0;
         rd_data  <= '0;
      end else begin
         state  <= state_nxt;
         CS_l   <= ctrl_nxt.cs_l;
         RD_l   <= ctrl_nxt.rd_l;
         WR_l   <= ctrl_nxt.wr_l;
         A_D_l  <= ctrl_nxt.a_d_l;
         en_tri <= ctrl_nxt.en_tri;
         busy   <= (state_nxt != ST_IDLE);
         done   <= (state_nxt == ST_DONE);
         if (state == ST_IDLE && start)
            addr_out <= addr;
         if (state == ST_DATA_STRB && count == 6'd0)
            rd_data <= bus_in;
      end
   end

`ifdef RTC_RD_DOUBLE_SAMPLE_EN
   logic [7:0] mid_sample;

   // rd_data already holds the final sample when DATA_HOLD hands over to DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mid_sample <= '0;
         rd_err     <= 1'b0;
      end else begin
         if (state == ST_DATA_STRB && count == 6'(T_STROBE / 2))
            mid_sample <= bus_in;
         rd_err <= (state_nxt == ST_DONE) && (mid_sample != rd_data);
      end
   end
`else
   assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_signal_control_lectura.sv
// Directed bench for signal_control_lectura (default timing 2/6/10, done 28 edges after accept).
module tb_signal_control_lectura;

   localparam int TS = 2;
   localparam int TB = 6;
   localparam int TG = 10;
   localparam int N  = 2*TS + 2*TB + TG + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] addr;
   logic [7:0] bus_in;
   logic [7:0] addr_out;
   logic       en_tri;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic       rd_err;
   logic       CS_l, RD_l, WR_l, A_D_l;

   int n_chk  = 0;
   int n_fail = 0;

   signal_control_lectura dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .addr     (addr),
      .bus_in   (bus_in),
      .addr_out (addr_out),
      .en_tri   (en_tri),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .rd_err   (rd_err),
      .CS_l     (CS_l),
      .RD_l     (RD_l),
      .WR_l     (WR_l),
      .A_D_l    (A_D_l)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {CS_l, RD_l, WR_l, A_D_l, en_tri} expected k edges after the accepting edge.
   function automatic logic [4:0] exp_ctrl(input int k);
      if (k < TS)                    return 5'b01101;
      else if (k < TS+TB)            return 5'b01001;
      else if (k < TS+TB+1)          return 5'b01101;
      else if (k < TS+TB+1+TG)       return 5'b11110;
      else if (k < 2*TS+TB+1+TG)     return 5'b01110;
      else if (k < 2*TS+2*TB+1+TG)   return 5'b00110;
      else if (k < N)                return 5'b01110;
      else                           return 5'b11110;
   endfunction

   function automatic logic [4:0] ctrl_now();
      return {CS_l, RD_l, WR_l, A_D_l, en_tri};
   endfunction

   initial begin
      int wr_low, rd_low, dcount, dat, d1, d2;

      // Reset held with start asserted
      rst = 1'b0; start = 1'b1; addr = 8'hFF; bus_in = 8'h00;
      repeat (3) tick();
      chk("rst_ctrl", 32'(ctrl_now()), 32'(5'b11110));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_addr_out", 32'(addr_out), 0);
      chk("rst_rd_err", 32'(rd_err), 0);
      start = 1'b0; rst = 1'b1;
      repeat (2) tick();
      chk("idle_ctrl", 32'(ctrl_now()), 32'(5'b11110));
      chk("idle_busy", 32'(busy), 0);

      // Single read, cycle-exact strobe table
      addr = 8'h21; bus_in = 8'h59; start = 1'b1;
      tick();
      start = 1'b0;
      wr_low = 0; rd_low = 0;
      for (int k = 0; k <= N + 1; k++) begin
         if (k > 0) tick();
         chk($sformatf("ctrl@%0d", k), 32'(ctrl_now()), 32'(exp_ctrl(k)));
         chk($sformatf("busy@%0d", k), 32'(busy), 32'(k <= N));
         chk($sformatf("done@%0d", k), 32'(done), 32'(k == N));
         if (!WR_l) begin
            wr_low++;
            chk($sformatf("addr_out@%0d", k), 32'(addr_out), 32'h21);
         end
         if (!RD_l) rd_low++;
         if (k == N - 2) chk("rd_data_early", 32'(rd_data), 0);
         if (k == N) begin
            chk("rd_data", 32'(rd_data), 32'h59);
            chk("rd_err_stable", 32'(rd_err), 0);
         end
      end
      chk("wr_low_cycles", 32'(wr_low), 32'(TB));
      chk("rd_low_cycles", 32'(rd_low), 32'(TB));

      // start re-pulsed during GAP and during DONE
      addr = 8'h33; start = 1'b1;
      tick();
      start = 1'b0;
      dcount = 0; dat = -1;
      for (int k = 1; k <= 45; k++) begin
         tick();
         if (done) begin dcount++; dat = k; end
         if (k == 14) chk("gap_ctrl", 32'(ctrl_now()), 32'(5'b11110));
         start = (k == 12) || (done === 1'b1);
         addr  = (k >= 12) ? 8'h7E : 8'h33;
      end
      start = 1'b0;
      chk("ignore_done_count", 32'(dcount), 1);
      chk("ignore_done_edge", 32'(dat), 32'(N));
      chk("ignore_addr_latch", 32'(addr_out), 32'h33);
      chk("ignore_busy", 32'(busy), 0);

      // Back-to-back reads, second start in the first IDLE cycle
      addr = 8'h00; bus_in = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      d1 = -1; d2 = -1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (done) begin
            if (d1 < 0) begin
               d1 = k;
               chk("b2b_first_data", 32'(rd_data), 32'hA5);
               chk("b2b_first_addr", 32'(addr_out), 32'h00);
            end else begin
               d2 = k;
            end
         end
         start = 1'b0;
         if (k == N + 1) begin
            chk("b2b_idle_busy", 32'(busy), 0);
            addr = 8'h02; bus_in = 8'h3C; start = 1'b1;
         end
      end
      chk("b2b_first_edge", 32'(d1), 32'(N));
      // DONE cycle plus one IDLE cycle separate the two transfers
      chk("b2b_spacing", 32'(d2 - d1), 32'(N + 2));
      chk("b2b_second_data", 32'(rd_data), 32'h3C);
      chk("b2b_second_addr", 32'(addr_out), 32'h02);

      // Asynchronous reset in mid DATA_STRB
      addr = 8'h44; bus_in = 8'h99; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 23; k++) tick();
      chk("abort_rd_low_before", 32'(RD_l), 0);
      #2 rst = 1'b0;
      #1;
      chk("abort_rd_l", 32'(RD_l), 1);
      chk("abort_cs_l", 32'(CS_l), 1);
      chk("abort_rd_data", 32'(rd_data), 0);
      chk("abort_busy", 32'(busy), 0);
      tick();
      rst = 1'b1;
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 0);
      chk("abort_idle_ctrl", 32'(ctrl_now()), 32'(5'b11110));

`ifdef RTC_RD_DOUBLE_SAMPLE_EN
      // Bus changes after the mid-strobe sample
      addr = 8'h10; bus_in = 8'h12; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= N + 1; k++) begin
         tick();
         if (k == 24) bus_in = 8'h13;
         if (k == N) begin
            chk("dbl_done", 32'(done), 1);
            chk("dbl_rd_data", 32'(rd_data), 32'h13);
            chk("dbl_rd_err", 32'(rd_err), 1);
         end
         if (k == N + 1) chk("dbl_rd_err_clear", 32'(rd_err), 0);
      end
      // Stable bus
      bus_in = 8'h77; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= N; k++) tick();
      chk("dbl_stable_done", 32'(done), 1);
      chk("dbl_stable_data", 32'(rd_data), 32'h77);
      chk("dbl_stable_err", 32'(rd_err), 0);
`else
      chk("rd_err_tied", 32'(rd_err), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
